// File: rtl/sultans_of_swing.sv
// Registered datapath stage: delayed copies of Ai/Bi plus the masked difference (Ai ^ Bi) & Ci.
// Define SULTANS_OF_SWING_PARITY_EN to add a registered parity output PARo.
module sultans_of_swing #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Ai,
  input  logic [WIDTH-1:0] Bi,
  input  logic [WIDTH-1:0] Ci,
  output logic [WIDTH-1:0] Ao,
  output logic [WIDTH-1:0] Bo,
`ifdef SULTANS_OF_SWING_PARITY_EN
  output logic             PARo,
`endif
  output logic [WIDTH-1:0] ANDo
);

  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] and_d, and_q;

  // Reset is folded into the next-state logic so it wins over data capture.
  always_comb begin
    a_d   = Ai;
    b_d   = Bi;
    and_d = (Ai ^ Bi) & Ci;
    if (reset) begin
      a_d   = '0;
      b_d   = '0;
      and_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    and_q <= and_d;
  end

  assign Ao   = a_q;
  assign Bo   = b_q;
  assign ANDo = and_q;

`ifdef SULTANS_OF_SWING_PARITY_EN
  logic par_d, par_q;

  always_comb begin
    par_d = ^and_d;
  end

  always_ff @(posedge clk) begin
    par_q <= par_d;
  end

  assign PARo = par_q;
`endif

endmodule

// File: tb/tb_sultans_of_swing.sv
// Self-checking bench for sultans_of_swing: directed vectors with literal expectations,
// then random stimulus checked every cycle against a behavioural model.
module tb_sultans_of_swing;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] Ai, Bi, Ci;
  logic [W-1:0] Ao, Bo, ANDo;
`ifdef SULTANS_OF_SWING_PARITY_EN
  logic         PARo;
`endif

  int vectors;
  int miscompares;

  // Model state: what the outputs must show after the most recent rising edge.
  logic [W-1:0] exp_a, exp_b, exp_and;
  logic         exp_par;
  bit           model_valid;

  sultans_of_swing #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .Ai   (Ai),
    .Bi   (Bi),
    .Ci   (Ci),
    .Ao   (Ao),
    .Bo   (Bo),
`ifdef SULTANS_OF_SWING_PARITY_EN
    .PARo (PARo),
`endif
    .ANDo (ANDo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Behavioural model: reset clears everything; otherwise copy and compute masked difference.
  always @(posedge clk) begin
    if (reset) begin
      exp_a       = '0;
      exp_b       = '0;
      exp_and     = '0;
      model_valid = 1'b1;
    end else begin
      exp_a   = Ai;
      exp_b   = Bi;
      exp_and = (Ai ^ Bi) & Ci;
    end
    exp_par = ^exp_and;
  end

  // Continuous comparison, half a cycle after each rising edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_Ao", Ao, exp_a);
      check("model_Bo", Bo, exp_b);
      check("model_ANDo", ANDo, exp_and);
`ifdef SULTANS_OF_SWING_PARITY_EN
      check("model_PARo", {{(W-1){1'b0}}, PARo}, {{(W-1){1'b0}}, exp_par});
`endif
    end
  end

  // Drive inputs (away from the rising edge), let one edge pass, check literal expectations.
  task automatic step(input string name, input logic r,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [W-1:0] ea, input logic [W-1:0] eb,
                      input logic [W-1:0] eand);
    reset = r;
    Ai    = a;
    Bi    = b;
    Ci    = c;
    @(negedge clk);
    check({name, "_Ao"}, Ao, ea);
    check({name, "_Bo"}, Bo, eb);
    check({name, "_ANDo"}, ANDo, eand);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_valid = 1'b0;
    reset       = 1'b1;
    Ai          = 4'b1111;
    Bi          = 4'b1111;
    Ci          = 4'b1111;

    step("reset", 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
`ifdef SULTANS_OF_SWING_PARITY_EN
    check("reset_PARo", {{(W-1){1'b0}}, PARo}, '0);
`endif

    step("basic0", 1'b0, 4'b0011, 4'b0110, 4'b0001, 4'b0011, 4'b0110, 4'b0001);
    step("basic1", 1'b0, 4'b1011, 4'b0111, 4'b1100, 4'b1011, 4'b0111, 4'b1100);
    step("basic2", 1'b0, 4'b1001, 4'b0111, 4'b0000, 4'b1001, 4'b0111, 4'b0000);
    step("basic3", 1'b0, 4'b1110, 4'b0011, 4'b1011, 4'b1110, 4'b0011, 4'b1001);
    step("compl0", 1'b0, 4'b0101, 4'b1010, 4'b1111, 4'b0101, 4'b1010, 4'b1111);
    step("compl1", 1'b0, 4'b0101, 4'b1010, 4'b0011, 4'b0101, 4'b1010, 4'b0011);
    step("equal0", 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    step("equal1", 1'b0, 4'b1111, 4'b0000, 4'b0110, 4'b1111, 4'b0000, 4'b0110);

    // Reset mid-stream, then immediate recovery with no bubble.
    step("stream0", 1'b0, 4'b1110, 4'b0011, 4'b1011, 4'b1110, 4'b0011, 4'b1001);
    step("midrst", 1'b1, 4'b1110, 4'b0011, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
    step("midrst2", 1'b1, 4'b1110, 4'b0011, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
    step("recover", 1'b0, 4'b1110, 4'b0011, 4'b1011, 4'b1110, 4'b0011, 4'b1001);

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 15) == 0);
      Ai    = W'($urandom);
      Bi    = W'($urandom);
      Ci    = W'($urandom);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
